// File: rtl/tx_phy_pkg.sv
// Shared types and helpers for the TX PHY power-up/power-down sequencer.
package tx_phy_pkg;

    localparam int NCH_DEF = 27;
    localparam int NCH_MAX = 64;

    typedef enum logic [2:0] {
        ST_OFF,
        ST_BIAS,
        ST_RAMP,
        ST_SETTLE,
        ST_ON,
        ST_DOWN
    } state_t;

    function automatic int ngrp(input int nch, input int group);
        return (nch + group - 1) / group;
    endfunction

    // Bits g*group .. min(g*group+group-1, nch-1) set; callers slice to their width.
    function automatic logic [NCH_MAX-1:0] group_mask(input int g, input int group, input int nch);
        logic [NCH_MAX-1:0] m;
        m = '0;
        for (int i = 0; i < NCH_MAX; i++) begin
            if (i >= g * group && i < (g + 1) * group && i < nch) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/tx_seq_timer.sv
// Loadable down counter shared by the bias, ramp-step and settle waits.
module tx_seq_timer #(
    parameter int W = 8
) (
    input  logic         data_tx_clk,
    input  logic         resetn,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         expired
);

    logic [W-1:0] count;

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge data_tx_clk) begin
        if (!resetn)               count <= '0;
        else if (load)             count <= value;
        else if (count != '0)      count <= count - 1'b1;
    end

    assign expired = (count == '0);

endmodule

// File: rtl/tx_phy_pwr_seq.sv
// Bias-first, group-ramped power sequencer for the TX PHY channel power-down pins.
module tx_phy_pwr_seq
    import tx_phy_pkg::*;
#(
    parameter int NCH       = NCH_DEF,
    parameter int GROUP     = 4,
    parameter int BIAS_WAIT = 256,
    parameter int STEP_WAIT = 16
) (
    input  logic           data_tx_clk,
    input  logic           resetn,
    input  logic           en,
    input  logic [NCH-1:0] ch_mask,
    output logic           pd_bias,
    output logic [NCH-1:0] reg_pd_ch,
    output logic           tx_ready,
    output logic           data_gate,
    output logic           busy
);

    localparam int NGRP = ngrp(NCH, GROUP);
    localparam int GW   = (NGRP > 1) ? $clog2(NGRP) : 1;
    localparam int TW   = $clog2((BIAS_WAIT > STEP_WAIT) ? BIAS_WAIT : STEP_WAIT);

    state_t         state_q, state_d;
    logic [GW-1:0]  grp_q, grp_d;
    logic [NCH-1:0] mask_q, mask_d;
    logic [NCH-1:0] pd_ch_d;
    logic           pd_bias_d, ready_d, busy_d;
    logic           tmr_load, tmr_expired;
    logic [TW-1:0]  tmr_value;

    function automatic logic [NCH-1:0] grp_bits(input int g);
        logic [NCH_MAX-1:0] m;
        m = group_mask(g, GROUP, NCH);
        return m[NCH-1:0];
    endfunction

    tx_seq_timer #(.W(TW)) u_timer (
        .data_tx_clk (data_tx_clk),
        .resetn      (resetn),
        .load        (tmr_load),
        .value       (tmr_value),
        .expired     (tmr_expired)
    );

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        grp_d     = grp_q;
        mask_d    = mask_q;
        pd_ch_d   = reg_pd_ch;
        pd_bias_d = pd_bias;
        ready_d   = tx_ready;
        tmr_load  = 1'b0;
        tmr_value = '0;

        if (!en && state_q inside {ST_BIAS, ST_RAMP, ST_SETTLE, ST_ON}) begin
            // Channels drop now; bias follows one edge later from DOWN.
            state_d  = ST_DOWN;
            pd_ch_d  = '1;
            ready_d  = 1'b0;
            grp_d    = '0;
            tmr_load = 1'b1;
        end else begin
            unique case (state_q)
                ST_OFF: begin
                    pd_bias_d = 1'b1;
                    pd_ch_d   = '1;
                    ready_d   = 1'b0;
                    if (en) begin
                        state_d   = ST_BIAS;
                        mask_d    = ch_mask;
                        pd_bias_d = 1'b0;
                        tmr_load  = 1'b1;
                        tmr_value = TW'(BIAS_WAIT - 1);
                    end
                end
                ST_BIAS: if (tmr_expired) begin
                    state_d   = ST_RAMP;
                    grp_d     = '0;
                    pd_ch_d   = reg_pd_ch & ~(grp_bits(0) & mask_q);
                    tmr_load  = 1'b1;
                    tmr_value = TW'(STEP_WAIT - 1);
                end
                ST_RAMP: if (tmr_expired) begin
                    tmr_load  = 1'b1;
                    tmr_value = TW'(STEP_WAIT - 1);
                    if (grp_q == GW'(NGRP - 1)) begin
                        state_d = ST_SETTLE;
                    end else begin
                        grp_d   = grp_q + 1'b1;
                        pd_ch_d = reg_pd_ch & ~(grp_bits(int'(grp_q) + 1) & mask_q);
                    end
                end
                ST_SETTLE: if (tmr_expired) begin
                    state_d = ST_ON;
                    ready_d = 1'b1;
                end
                ST_ON: ;
                ST_DOWN: begin
                    state_d   = ST_OFF;
                    pd_bias_d = 1'b1;
                end
                default: state_d = ST_OFF;
            endcase
        end

        busy_d = state_d inside {ST_BIAS, ST_RAMP, ST_SETTLE, ST_DOWN};
    end

    always_ff @(posedge data_tx_clk) begin
        if (!resetn) begin
            state_q   <= ST_OFF;
            grp_q     <= '0;
            mask_q    <= '0;
            pd_bias   <= 1'b1;
            reg_pd_ch <= '1;
            tx_ready  <= 1'b0;
            data_gate <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            grp_q     <= grp_d;
            mask_q    <= mask_d;
            pd_bias   <= pd_bias_d;
            reg_pd_ch <= pd_ch_d;
            tx_ready  <= ready_d;
            data_gate <= ~ready_d;
            busy      <= busy_d;
        end
    end

endmodule

// File: doc/tx_phy_pwr_seq.md
# tx_phy_pwr_seq

Power-up/power-down sequencer for the 27-channel TX PHY digital block. It drives the bias power-down and per-channel power-down controls, bringing up the bias first and then powering the enabled channels in small groups so supply inrush stays bounded. It asserts a ready flag once all channels have settled, and that flag gates lane data. It sits between the link control logic and the PHY's analog control pins, running on the divided data clock.

## Interface
Parameters:
- NCH, 27, number of TX channels
- GROUP, 4, channels powered per ramp step
- BIAS_WAIT, 256, cycles from bias enable to first channel step (≥2)
- STEP_WAIT, 16, cycles per ramp step and final settle (≥2)

Ports:
- data_tx_clk  in  1  sequencer clock
- resetn  in  1  synchronous, active-low reset; clock data_tx_clk
- en  in  1  level request: 1 = power up and stay up, 0 = power down
- ch_mask  in  NCH  1 = channel in use; sampled on the OFF→BIAS transition only
- pd_bias  out  1  bias power-down, 1 = down
- reg_pd_ch  out  NCH  channel power-down, bit i = channel i, 1 = down
- tx_ready  out  1  all masked channels powered and settled
- data_gate  out  1  1 = lanes must send idle; equals ~tx_ready
- busy  out  1  sequence in progress (BIAS, RAMP, SETTLE, DOWN)

## Operation
- All outputs are registered.
- Reset values: pd_bias=1, reg_pd_ch=all ones, tx_ready=0, data_gate=1, busy=0, state=OFF.
- NGRP = ceil(NCH/GROUP) = 7 with defaults. Group g covers channels g*GROUP to min(g*GROUP+GROUP-1, NCH-1).
- States:
  - OFF: pd_bias=1, all pd_ch=1. If en=1, latch ch_mask and go to BIAS.
  - BIAS: pd_bias=0. Stay exactly BIAS_WAIT cycles, then go to RAMP with g=0.
  - RAMP: on entry to step g, clear reg_pd_ch bits of group g where the latched mask is 1. Hold each step STEP_WAIT cycles. After step NGRP-1 go to SETTLE.
  - SETTLE: hold STEP_WAIT cycles, then go to ON.
  - ON: tx_ready=1. Remain while en=1.
  - DOWN: set all reg_pd_ch=1 on entry, clear tx_ready, keep pd_bias=0 for exactly one cycle, then go to OFF (pd_bias=1).
- en=0 in BIAS, RAMP, SETTLE or ON goes to DOWN on the next edge. This aborts mid-sequence; timer and group index are cleared.
- en=1 sampled during DOWN is ignored; it is acted on once back in OFF.
- Unmasked channels never power up. An all-zero mask still runs the full sequence and reaches ON.
- Channels are never powered while pd_bias=1. Bias is never downed while any pd_ch bit is 0.
- ch_mask changes after latching are ignored until the next OFF→BIAS transition.

## Timing
- Edge 0 is the edge that samples en=1 in OFF. pd_bias falls after edge 0.
- Group g is released after edge BIAS_WAIT + g*STEP_WAIT.
- tx_ready and ~data_gate rise after edge T_UP = BIAS_WAIT + (NGRP+1)*STEP_WAIT, which is 384 with defaults.
- Power-down starts on the edge that samples en=0: reg_pd_ch goes all ones and tx_ready=0 after that edge. pd_bias=1 follows one edge later. Latency is 2 cycles from en=0 to OFF.
- Reset asserted mid-sequence forces reset values on the same edge: bias and channels are downed simultaneously.
- The timer is a down counter loaded with WAIT-1 and expiring at 0. Its width is clog2 of max(BIAS_WAIT, STEP_WAIT).

## Structure
- Shared package tx_phy_pkg:
  - state enum (OFF, BIAS, RAMP, SETTLE, ON, DOWN)
  - NCH default
  - constant function for NGRP (ceil division)
  - function returning the group bit mask for index g
- Sub-module tx_seq_timer: loadable down counter with load, value and expire outputs. It is reused for the BIAS, RAMP-step and SETTLE waits.
- Top level: FSM, group index counter, latched mask and output registers.

## Test plan
- Reset, then en=1 with ch_mask=all ones:
  - pd_bias falls after edge 0.
  - Bits 0–3 clear at edge 256, bits 4–7 at 272, and so on; bits 24–26 clear at 352.
  - tx_ready rises at 384.
- ch_mask=27'h0000005 (channels 0 and 2):
  - Only bits 0 and 2 clear, at edge 256.
  - tx_ready still rises at 384; all other pd bits stay 1.
- en drops at edge 300 (mid-RAMP):
  - reg_pd_ch=all ones after edge 300 and pd_bias=1 after edge 301.
  - Re-raising en restarts with a full 384-cycle sequence.
- In ON, toggle ch_mask: outputs are unchanged. Then en=0 → DOWN for 1 cycle → OFF, with the bias/channel ordering preserved.
- Assert resetn=0 at edge 200 (BIAS): all outputs take reset values on that edge. With en held high after release, the sequence restarts and reaches ON 384 cycles after the first post-reset edge.
- Assertions on every cycle:
  - (pd_bias=1) ⇒ reg_pd_ch = all ones.
  - data_gate = ~tx_ready.
  - tx_ready ⇒ state is ON.
